// File: rtl/equalize_sequencer.sv
// Frame-level controller for the histogram-equalization output pipeline: finds CdfMin,
// derives the divisor, launches the output pipeline and flips the ping-pong output base.
module equalize_sequencer #(
  parameter logic [15:0] CDF_BASE     = 16'h0000,
  parameter int unsigned NUM_BINS     = 256,
  parameter logic [19:0] PIPE_TIMEOUT = 20'hFFFFF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         frame_start,
  input  logic [19:0]  pixel_count,
  output logic [15:0]  CdfReadAddress,
  input  logic [127:0] CdfReadBus,
  output logic [19:0]  CdfMin,
  output logic [19:0]  divisor,
  output logic         pipe_start,
  input  logic         pipe_done,
  output logic         output_base_offset,
  output logic         busy,
  output logic         frame_done,
  output logic         err_empty,
  output logic         err_timeout
);

  localparam int unsigned     CntW     = $clog2(NUM_BINS + 1);
  localparam logic [15:0]     LastAddr = CDF_BASE + 16'(NUM_BINS - 1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(NUM_BINS);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StCalc,
    StLaunch,
    StRun,
    StFinish
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [19:0]     cdf_min_q, cdf_min_d;
  logic [19:0]     div_q, div_d;
  logic [19:0]     wd_q, wd_d;
  logic            offset_q, offset_d;
  logic            err_empty_q, err_empty_d;
  logic            err_to_q, err_to_d;

  logic [19:0] bin_val;
  logic        unused_rd_bits;

  assign bin_val        = CdfReadBus[19:0];
  assign unused_rd_bits = ^CdfReadBus[127:20];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= CDF_BASE;
      cnt_q       <= '0;
      cdf_min_q   <= '0;
      div_q       <= 20'd1;
      wd_q        <= '0;
      offset_q    <= 1'b0;
      err_empty_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cdf_min_q   <= cdf_min_d;
      div_q       <= div_d;
      wd_q        <= wd_d;
      offset_q    <= offset_d;
      err_empty_q <= err_empty_d;
      err_to_q    <= err_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cdf_min_d   = cdf_min_q;
    div_d       = div_q;
    wd_d        = wd_q;
    offset_d    = offset_q;
    err_empty_d = err_empty_q;
    err_to_d    = err_to_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StScan;
          addr_d  = CDF_BASE;
          cnt_d   = '0;
        end
      end
      StScan: begin
        if (addr_q != LastAddr) addr_d = addr_q + 16'd1;
        cnt_d = cnt_q + CntW'(1);
        // cnt_q counts SCAN cycles; data for bin cnt_q-1 is on the bus when cnt_q >= 1
        if (cnt_q != '0) begin
          if (bin_val != '0) begin
            cdf_min_d = bin_val;
            state_d   = StCalc;
          end else if (cnt_q == LastCnt) begin
            cdf_min_d   = '0;
            err_empty_d = 1'b1;
            state_d     = StFinish;
          end
        end
      end
      StCalc: begin
        div_d   = (pixel_count > cdf_min_q) ? (pixel_count - cdf_min_q) : 20'd1;
        state_d = StLaunch;
      end
      StLaunch: begin
        wd_d    = '0;
        state_d = StRun;
      end
      StRun: begin
        if (pipe_done) begin
          offset_d = ~offset_q;
          state_d  = StFinish;
        end else if ((wd_q + 20'd1) == PIPE_TIMEOUT) begin
          err_to_d = 1'b1;
          state_d  = StFinish;
        end else begin
          wd_d = wd_q + 20'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign CdfReadAddress     = addr_q;
  assign CdfMin             = cdf_min_q;
  assign divisor            = div_q;
  assign pipe_start         = (state_q == StLaunch);
  assign frame_done         = (state_q == StFinish);
  assign busy               = (state_q != StIdle);
  assign output_base_offset = offset_q;
  assign err_empty          = err_empty_q;
  assign err_timeout        = err_to_q;

endmodule

// File: tb/tb_equalize_sequencer.sv
// Directed bench for equalize_sequencer: scoreboard of expected launches, CDF memory model,
// and a second instance with a short watchdog for the timeout case.
module tb_equalize_sequencer;

  localparam logic [15:0]  Base = 16'h0040;
  localparam int unsigned  Bins = 256;
  localparam logic [107:0] Junk = {27{4'hA}};

  typedef struct {
    logic [19:0] cmin;
    logic [19:0] div;
    int          ps_cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, frame_start, pipe_done, frame_start_to, pipe_done_to;
  logic [19:0]  pixel_count;
  logic [15:0]  rd_addr, rd_addr_to;
  logic [127:0] rd_bus, rd_bus_to;
  logic [19:0]  cdf_min, divisor, cdf_min_to, divisor_to;
  logic         pipe_start, offset, busy, frame_done, err_empty, err_timeout;
  logic         pipe_start_to, offset_to, busy_to, frame_done_to, err_empty_to, err_timeout_to;

  equalize_sequencer #(
    .CDF_BASE(Base),
    .NUM_BINS(Bins)
  ) u_dut (
    .clock             (clock),
    .reset             (reset),
    .frame_start       (frame_start),
    .pixel_count       (pixel_count),
    .CdfReadAddress    (rd_addr),
    .CdfReadBus        (rd_bus),
    .CdfMin            (cdf_min),
    .divisor           (divisor),
    .pipe_start        (pipe_start),
    .pipe_done         (pipe_done),
    .output_base_offset(offset),
    .busy              (busy),
    .frame_done        (frame_done),
    .err_empty         (err_empty),
    .err_timeout       (err_timeout)
  );

  equalize_sequencer #(
    .PIPE_TIMEOUT(20'd50)
  ) u_dut_to (
    .clock             (clock),
    .reset             (reset),
    .frame_start       (frame_start_to),
    .pixel_count       (pixel_count),
    .CdfReadAddress    (rd_addr_to),
    .CdfReadBus        (rd_bus_to),
    .CdfMin            (cdf_min_to),
    .divisor           (divisor_to),
    .pipe_start        (pipe_start_to),
    .pipe_done         (pipe_done_to),
    .output_base_offset(offset_to),
    .busy              (busy_to),
    .frame_done        (frame_done_to),
    .err_empty         (err_empty_to),
    .err_timeout       (err_timeout_to)
  );

  logic [19:0] mem [Bins];

  function automatic logic [19:0] lookup(input logic [15:0] addr, input logic [15:0] base);
    logic [15:0] idx;
    idx = addr - base;
    if (idx < 16'(Bins)) return mem[idx[7:0]];
    return 20'hBAD00;
  endfunction

  // 1-cycle read latency, junk in the ignored upper bits
  always @(posedge clock) begin
    rd_bus    <= {Junk, lookup(rd_addr, Base)};
    rd_bus_to <= {Junk, lookup(rd_addr_to, 16'h0000)};
  end

  int ecount = 0;
  int ps_cnt = 0, fd_cnt = 0, ps_to_cnt = 0;
  always @(posedge clock) ecount <= ecount + 1;
  always @(negedge clock) begin
    if (pipe_start)    ps_cnt    <= ps_cnt + 1;
    if (frame_done)    fd_cnt    <= fd_cnt + 1;
    if (pipe_start_to) ps_to_cnt <= ps_to_cnt + 1;
  end

  int   total = 0, bad = 0;
  int   t0 = 0, at, ps_before, fd_before;
  logic exp_off;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int first, input logic [19:0] val);
    for (int i = 0; i < int'(Bins); i++) begin
      if (i < first) mem[i] = '0;
      else if (i == first) mem[i] = val;
      else mem[i] = 20'(i + 3);
    end
  endtask

  task automatic start_frame(input bit to);
    @(posedge clock); #1;
    if (to) frame_start_to = 1'b1;
    else frame_start = 1'b1;
    t0 = ecount;
    @(posedge clock); #1;
    frame_start    = 1'b0;
    frame_start_to = 1'b0;
  endtask

  // which: 0 pipe_start, 1 frame_done, 2 frame_done of the timeout instance
  task automatic wait_pulse(input int which, input int limit, output int cyc);
    cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if ((which == 0 && pipe_start) || (which == 1 && frame_done) ||
          (which == 2 && frame_done_to)) begin
        cyc = ecount - t0;
        break;
      end
    end
  endtask

  task automatic wait_until(input int n);
    while ((ecount - t0) < n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic pulse_done();
    pipe_done = 1'b1;
    @(posedge clock); #1;
    pipe_done = 1'b0;
  endtask

  task automatic expect_launch(input string tag);
    exp_t e;
    int   c;
    wait_pulse(0, 400, c);
    if (sb.size() == 0) begin
      e.cmin = 'x; e.div = 'x; e.ps_cyc = -2;
    end else begin
      e = sb.pop_front();
    end
    check({tag, "_ps_cyc"}, c, e.ps_cyc);
    check({tag, "_cdfmin"}, {12'd0, cdf_min}, {12'd0, e.cmin});
    check({tag, "_divisor"}, {12'd0, divisor}, {12'd0, e.div});
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; frame_start_to = 1'b0;
    pipe_done = 1'b0; pipe_done_to = 1'b0; pixel_count = '0;
    fill(0, 20'd5);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_addr", {16'd0, rd_addr}, {16'd0, Base});
    check("rst_cdfmin", {12'd0, cdf_min}, 32'd0);
    check("rst_divisor", {12'd0, divisor}, 32'd1);
    check("rst_offset", {31'd0, offset}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pipe_start", {31'd0, pipe_start}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_err_empty", {31'd0, err_empty}, 32'd0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    exp_off = 1'b0;

    // Frame A: bin0 = 5
    pixel_count = 20'd65536;
    sb.push_back('{cmin: 20'd5, div: 20'd65531, ps_cyc: 4});
    start_frame(1'b0);
    expect_launch("A");
    check("A_busy", {31'd0, busy}, 32'd1);
    wait_until(100);
    pulse_done();
    wait_pulse(1, 10, at);
    exp_off = ~exp_off;
    check("A_fd_cyc", at, 101);
    check("A_offset", {31'd0, offset}, {31'd0, exp_off});
    @(posedge clock); #1;
    check("A_busy_low", {31'd0, busy}, 32'd0);
    check("A_ps_cnt", ps_cnt, 1);

    // Empty CDF
    fill(int'(Bins), 20'd0);
    ps_before = ps_cnt;
    start_frame(1'b0);
    wait_pulse(1, 400, at);
    check("E_fd_cyc", at, 258);
    check("E_err_empty", {31'd0, err_empty}, 32'd1);
    check("E_cdfmin", {12'd0, cdf_min}, 32'd0);
    check("E_offset", {31'd0, offset}, {31'd0, exp_off});
    @(posedge clock); #1;
    check("E_no_ps", ps_cnt, ps_before);
    check("E_busy_low", {31'd0, busy}, 32'd0);
    check("E_err_sticky", {31'd0, err_empty}, 32'd1);

    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_off = 1'b0;
    @(negedge clock);
    check("R_err_empty_clr", {31'd0, err_empty}, 32'd0);
    check("R_offset", {31'd0, offset}, 32'd0);

    // Frames B: first non-zero bin 37
    fill(37, 20'd12);
    pixel_count = 20'd1000;
    for (int f = 0; f < 2; f++) begin
      sb.push_back('{cmin: 20'd12, div: 20'd988, ps_cyc: 41});
      start_frame(1'b0);
      expect_launch("B");
      wait_until(60);
      pulse_done();
      wait_pulse(1, 10, at);
      exp_off = ~exp_off;
      check("B_fd_cyc", at, 61);
      check("B_offset", {31'd0, offset}, {31'd0, exp_off});
      @(posedge clock); #1;
    end

    // Frame D: pixel_count equals CdfMin, frame_start during RUN ignored
    fill(0, 20'd40);
    pixel_count = 20'd40;
    ps_before = ps_cnt;
    sb.push_back('{cmin: 20'd40, div: 20'd1, ps_cyc: 4});
    start_frame(1'b0);
    expect_launch("D");
    wait_until(10);
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    wait_until(20);
    pulse_done();
    wait_pulse(1, 10, at);
    exp_off = ~exp_off;
    check("D_fd_cyc", at, 21);
    check("D_offset", {31'd0, offset}, {31'd0, exp_off});
    repeat (20) begin
      @(posedge clock); #1;
    end
    check("D_no_requeue", {31'd0, busy}, 32'd0);
    check("D_ps_once", ps_cnt, ps_before + 1);
    pulse_done();
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("D_idle_done_ignored", {31'd0, offset}, {31'd0, exp_off});

    // Frame F: reset three cycles into RUN
    fill(0, 20'd5);
    pixel_count = 20'd100;
    ps_before = ps_cnt;
    fd_before = fd_cnt;
    sb.push_back('{cmin: 20'd5, div: 20'd95, ps_cyc: 4});
    start_frame(1'b0);
    expect_launch("F");
    wait_until(7);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("F_busy", {31'd0, busy}, 32'd0);
    check("F_offset", {31'd0, offset}, 32'd0);
    pulse_done();
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("F_offset_after_done", {31'd0, offset}, 32'd0);
    check("F_no_fd", fd_cnt, fd_before);
    check("F_ps_cnt", ps_cnt, ps_before + 1);

    // Watchdog on the short-timeout instance
    start_frame(1'b1);
    wait_pulse(2, 200, at);
    check("T_fd_window", {31'd0, (at >= 54 && at <= 57)}, 32'd1);
    check("T_err_timeout", {31'd0, err_timeout_to}, 32'd1);
    check("T_offset", {31'd0, offset_to}, 32'd0);
    @(posedge clock); #1;
    check("T_busy_low", {31'd0, busy_to}, 32'd0);
    check("T_ps_cnt", ps_to_cnt, 1);
    check("T_err_sticky", {31'd0, err_timeout_to}, 32'd1);
    check("T_main_no_timeout", {31'd0, err_timeout}, 32'd0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
